// File: rtl/ps2_rx_decoder.sv
// Host-side PS/2 keyboard receiver: synchronizes and glitch-filters the raw lines,
// deserializes 11-bit frames and folds E0/F0 prefixes into single key events.
module ps2_rx_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] ps2_key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       key_extended,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Odd parity holds when data plus parity carry an odd number of ones.
  function automatic logic f_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic          r_c_filt, r_c_filt_d;
  logic [FW-1:0] r_filt_cnt;
  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          r_brk, r_ext;
  logic [7:0]    r_rx_byte, r_key_code;
  logic          r_rx_valid, r_key_valid, r_key_rel, r_key_ext, r_frame_err;
  logic [1:0]    r_err_code;
  logic          w_fall, w_d;

  // Two-flop synchronizers; idle-high lines reset to 1.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_c_s1 <= 1'b1;
      r_c_s2 <= 1'b1;
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= PS2C;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= PS2D;
      r_d_s2 <= r_d_s1;
    end
  end

  // Glitch filter: accept a new clock level after FILTER_LEN consecutive differing samples.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_c_filt   <= 1'b1;
      r_c_filt_d <= 1'b1;
      r_filt_cnt <= {FW{1'b0}};
    end else begin
      r_c_filt_d <= r_c_filt;
      if (r_c_s2 == r_c_filt) begin
        r_filt_cnt <= {FW{1'b0}};
      end else if (r_filt_cnt == FILT_LAST) begin
        r_c_filt   <= r_c_s2;
        r_filt_cnt <= {FW{1'b0}};
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fall = r_c_filt_d & ~r_c_filt;
  assign w_d    = r_d_s2;

  // Frame FSM, timeout, frame evaluation and prefix tracking with registered outputs.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_to_cnt    <= {TW{1'b0}};
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_valid <= 1'b0;
      r_key_rel   <= 1'b0;
      r_key_ext   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_rx_valid  <= 1'b0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if ((r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST)) begin
        r_state     <= S_IDLE;
        r_to_cnt    <= {TW{1'b0}};
        r_frame_err <= 1'b1;
        r_err_code  <= 2'b11;
        r_brk       <= 1'b0;
        r_ext       <= 1'b0;
      end else begin
        if (r_state == S_IDLE || w_fall) begin
          r_to_cnt <= {TW{1'b0}};
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
        case (r_state)
          S_IDLE: begin
            if (w_fall && !w_d) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            if (w_fall) begin
              r_shift   <= {w_d, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_PARITY;
              end
            end
          end
          S_PARITY: begin
            if (w_fall) begin
              r_par   <= w_d;
              r_state <= S_STOP;
            end
          end
          S_STOP: begin
            if (w_fall) begin
              r_state <= S_IDLE;
              if (!f_parity_ok(r_shift, r_par)) begin
                r_frame_err <= 1'b1;
                r_err_code  <= 2'b01;
                r_brk       <= 1'b0;
                r_ext       <= 1'b0;
              end else if (!w_d) begin
                r_frame_err <= 1'b1;
                r_err_code  <= 2'b10;
                r_brk       <= 1'b0;
                r_ext       <= 1'b0;
              end else begin
                r_rx_byte  <= r_shift;
                r_rx_valid <= 1'b1;
                if (r_shift == 8'hF0) begin
                  r_brk <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                  r_ext <= 1'b1;
                end else begin
                  r_key_code  <= r_shift;
                  r_key_rel   <= r_brk;
                  r_key_ext   <= r_ext;
                  r_key_valid <= 1'b1;
                  r_brk       <= 1'b0;
                  r_ext       <= 1'b0;
                end
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_byte      = r_rx_byte;
  assign rx_valid     = r_rx_valid;
  assign ps2_key_code = r_key_code;
  assign key_valid    = r_key_valid;
  assign key_released = r_key_rel;
  assign key_extended = r_key_ext;
  assign frame_err    = r_frame_err;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Self-checking bench for ps2_rx_decoder: a scoreboard of expected bytes, key events
// and errors is filled as frames are sent and drained by an output monitor.
module tb_ps2_rx_decoder;

  localparam int FL = 8;
  localparam int TO = 200;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [7:0] rx_byte, ps2_key_code;
  logic       rx_valid, key_valid, key_released, key_extended, frame_err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rx[$];
  logic [9:0] exp_key[$];
  logic [1:0] exp_err[$];
  logic       prev_rx = 1'b0;

  ps2_rx_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .ck(ck), .rst_n(rst_n), .PS2C(PS2C), .PS2D(PS2D),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .ps2_key_code(ps2_key_code),
    .key_valid(key_valid), .key_released(key_released), .key_extended(key_extended),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 ck = ~ck;

  initial begin
    #20ms;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  // Scoreboard drain: every output pulse must match the head of its queue.
  always @(negedge ck) begin
    logic [7:0] e8;
    logic [9:0] ek;
    logic [1:0] e2;
    if (rx_valid) begin
      total++;
      if (exp_rx.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected got=%h", rx_byte);
      end else begin
        e8 = exp_rx.pop_front();
        if (rx_byte !== e8) begin
          bad++;
          $display("FAIL rx_byte got=%h exp=%h", rx_byte, e8);
        end
      end
      total++;
      if (prev_rx) begin
        bad++;
        $display("FAIL rx_consecutive got=1 exp=0");
      end
    end
    if (key_valid) begin
      total++;
      if (exp_key.size() == 0) begin
        bad++;
        $display("FAIL key_unexpected got=%h rel=%b ext=%b", ps2_key_code, key_released, key_extended);
      end else begin
        ek = exp_key.pop_front();
        if ({ps2_key_code, key_released, key_extended} !== ek || !rx_valid) begin
          bad++;
          $display("FAIL key_event got=%h/%b/%b/rxv=%b exp=%h/%b/%b/rxv=1",
                   ps2_key_code, key_released, key_extended, rx_valid, ek[9:2], ek[1], ek[0]);
        end
      end
    end
    if (frame_err) begin
      total++;
      if (exp_err.size() == 0) begin
        bad++;
        $display("FAIL err_unexpected got=%b", err_code);
      end else begin
        e2 = exp_err.pop_front();
        if (err_code !== e2) begin
          bad++;
          $display("FAIL err_code got=%b exp=%b", err_code, e2);
        end
      end
    end
    prev_rx = rx_valid;
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic par_ok, input logic stop);
    return {stop, (par_ok ? ~^b : ^b), b, 1'b0};
  endfunction

  // Sends the first n bits of frame f; glitch_at inserts a short PS2C low pulse before that bit.
  task automatic send_bits(input logic [10:0] f, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      PS2D = f[i];
      if (i == glitch_at) begin
        repeat (2) @(negedge ck);
        PS2C = 1'b0;
        repeat (FL - 1) @(negedge ck);
        PS2C = 1'b1;
      end
      repeat (10) @(negedge ck);
      PS2C = 1'b0;
      repeat (20) @(negedge ck);
      PS2C = 1'b1;
      repeat (10) @(negedge ck);
    end
    PS2D = 1'b1;
    repeat (20) @(negedge ck);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_bits(mk(b, 1'b1, 1'b1), 11, -1);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_rx.size() != 0 || exp_key.size() != 0 || exp_err.size() != 0) begin
      bad++;
      $display("FAIL %s_drained got=rx%0d/key%0d/err%0d exp=0/0/0",
               name, exp_rx.size(), exp_key.size(), exp_err.size());
      exp_rx.delete();
      exp_key.delete();
      exp_err.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({rx_byte, rx_valid, ps2_key_code, key_valid, key_released, key_extended, frame_err, err_code} !== 23'd0) begin
      bad++;
      $display("FAIL %s got=rx%h v%b k%h kv%b r%b e%b fe%b ec%b exp=all0", name,
               rx_byte, rx_valid, ps2_key_code, key_valid, key_released, key_extended, frame_err, err_code);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge ck);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (20) @(negedge ck);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_make();
    exp_rx.push_back(8'h16);
    exp_key.push_back({8'h16, 1'b0, 1'b0});
    send_good(8'h16);
    check_drained("make");
    total++;
    if (ps2_key_code !== 8'h16 || key_released !== 1'b0 || key_extended !== 1'b0) begin
      bad++;
      $display("FAIL make_hold got=%h/%b/%b exp=16/0/0", ps2_key_code, key_released, key_extended);
    end
  endtask

  task automatic test_break();
    exp_rx.push_back(8'hF0);
    send_good(8'hF0);
    check_drained("break_prefix");
    exp_rx.push_back(8'h16);
    exp_key.push_back({8'h16, 1'b1, 1'b0});
    send_good(8'h16);
    check_drained("break");
  endtask

  task automatic test_ext_break();
    exp_rx.push_back(8'hE0);
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h75);
    exp_key.push_back({8'h75, 1'b1, 1'b1});
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    exp_rx.push_back(8'h1E);
    exp_key.push_back({8'h1E, 1'b0, 1'b0});
    send_good(8'h1E);
    check_drained("ext_break");
    // Repeated prefixes followed by FF still complete one event.
    exp_rx.push_back(8'hE0);
    exp_rx.push_back(8'hE0);
    exp_rx.push_back(8'hFF);
    exp_key.push_back({8'hFF, 1'b0, 1'b1});
    send_good(8'hE0);
    send_good(8'hE0);
    send_good(8'hFF);
    check_drained("repeat_prefix");
  endtask

  task automatic test_errors();
    exp_rx.push_back(8'h16);
    exp_key.push_back({8'h16, 1'b0, 1'b0});
    send_good(8'h16);
    exp_rx.push_back(8'hF0);
    send_good(8'hF0);
    exp_err.push_back(2'b01);
    send_bits(mk(8'h1E, 1'b0, 1'b1), 11, -1);
    check_drained("parity");
    total++;
    if (rx_byte !== 8'hF0 || ps2_key_code !== 8'h16 || err_code !== 2'b01) begin
      bad++;
      $display("FAIL parity_hold got=rx%h k%h ec%b exp=rxF0 k16 ec01", rx_byte, ps2_key_code, err_code);
    end
    // Break flag must have been cleared by the error.
    exp_rx.push_back(8'h22);
    exp_key.push_back({8'h22, 1'b0, 1'b0});
    send_good(8'h22);
    exp_err.push_back(2'b10);
    send_bits(mk(8'h33, 1'b1, 1'b0), 11, -1);
    exp_err.push_back(2'b01);
    send_bits(mk(8'h33, 1'b0, 1'b0), 11, -1);
    check_drained("stop_err");
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h1E);
    exp_key.push_back({8'h1E, 1'b1, 1'b0});
    send_good(8'hF0);
    send_good(8'h1E);
    check_drained("recovery");
  endtask

  task automatic test_glitch();
    exp_rx.push_back(8'h29);
    exp_key.push_back({8'h29, 1'b0, 1'b0});
    send_bits(mk(8'h29, 1'b1, 1'b1), 11, 4);
    check_drained("glitch");
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int n;
    bit seen;
    f = mk(8'h16, 1'b1, 1'b1);
    exp_rx.push_back(8'hF0);
    send_good(8'hF0);
    exp_err.push_back(2'b11);
    send_bits(f, 4, -1);
    PS2D = f[4];
    repeat (10) @(negedge ck);
    PS2C = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge ck);
      n++;
      if (n == 20) PS2C = 1'b1;
      if (frame_err) seen = 1'b1;
    end
    PS2C = 1'b1;
    PS2D = 1'b1;
    total++;
    if (!seen || n < TO || n > TO + 25) begin
      bad++;
      $display("FAIL timeout_latency got=%0d seen=%b exp=%0d..%0d", n, seen, TO, TO + 25);
    end
    repeat (20) @(negedge ck);
    check_drained("timeout");
    exp_rx.push_back(8'h16);
    exp_key.push_back({8'h16, 1'b0, 1'b0});
    send_good(8'h16);
    check_drained("after_timeout");
  endtask

  task automatic test_reset_mid();
    send_bits(mk(8'h16, 1'b1, 1'b1), 6, -1);
    rst_n = 1'b0;
    repeat (3) @(negedge ck);
    check_all_zero("reset_mid");
    rst_n = 1'b1;
    repeat (30) @(negedge ck);
    check_all_zero("post_reset_quiet");
    check_drained("reset_mid");
    exp_rx.push_back(8'h16);
    exp_key.push_back({8'h16, 1'b0, 1'b0});
    send_good(8'h16);
    check_drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_errors();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
